// File: rtl/gpio_stream_bridge.sv
// gpio_stream_bridge: GPIO-side pin/word stream bridge in the io_clk domain.
// Packs PIN_W-wide pin beats into WORD_W words and unpacks result words into
// pin beats. Also synchronises asynchronous status bits and keeps sticky
// rising-edge flags for them.
`timescale 1ns/1ps
module gpio_stream_bridge #(
    parameter int PIN_W       = 11,
    parameter int WORD_W      = 55,
    parameter int NUM_STATUS  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  io_clk,
    input  logic                  io_rst_n,
    // pack path
    input  logic                  pin_wenq,
    input  logic [PIN_W-1:0]      pin_wdata,
    output logic                  pin_wfull_n,
    output logic                  ovf_o,
    output logic                  word_out_valid,
    output logic [WORD_W-1:0]     word_out_data,
    input  logic                  word_out_ready,
    // unpack path
    input  logic                  word_in_valid,
    input  logic [WORD_W-1:0]     word_in_data,
    output logic                  word_in_ready,
    input  logic                  pin_deq,
    output logic [PIN_W-1:0]      pin_rdata,
    output logic                  pin_rempty_n,
    // status path
    input  logic [NUM_STATUS-1:0] status_async_i,
    output logic [NUM_STATUS-1:0] status_o,
    output logic [NUM_STATUS-1:0] status_sticky_o,
    input  logic [NUM_STATUS-1:0] status_clr
);

    localparam int BEATS = (WORD_W + PIN_W - 1) / PIN_W;
    localparam int EXT_W = BEATS * PIN_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] NBEAT = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Pack path
    // ------------------------------------------------------------------
    // The assembly register is a whole number of beats wide. The bits of the
    // final beat above WORD_W are stored but never reach the holding register.
    logic [EXT_W-1:0]  r_asm;
    logic [EXT_W-1:0]  w_asm;
    logic [CNT_W-1:0]  r_wcnt;
    logic [WORD_W-1:0] r_hold;
    logic              r_hvld;
    logic              r_ovf;
    logic              w_full;
    logic              w_acc;
    logic              w_fin;

    // Beat acceptance. Full is taken from registers only, so the result does
    // not change with word_out_ready in the same cycle.
    always_comb begin
        w_full = r_hvld && (r_wcnt == LAST);
        w_acc  = pin_wenq && !w_full;
        w_fin  = w_acc && (r_wcnt == LAST);
        w_asm  = r_asm;
        w_asm[r_wcnt*PIN_W +: PIN_W] = pin_wdata;
    end

    // Assembly, beat counter, holding register and sticky overflow.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_asm  <= '0;
            r_wcnt <= '0;
            r_hold <= '0;
            r_hvld <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_asm  <= w_asm;
                r_wcnt <= w_fin ? '0 : r_wcnt + ONE;
            end
            if (pin_wenq && w_full)
                r_ovf <= 1'b1;
            // A final beat can only land while the holding register is empty.
            if (w_fin) begin
                r_hold <= w_asm[WORD_W-1:0];
                r_hvld <= 1'b1;
            end else if (word_out_ready) begin
                r_hvld <= 1'b0;
            end
        end
    end

    assign pin_wfull_n    = !w_full;
    assign ovf_o          = r_ovf;
    assign word_out_valid = r_hvld;
    assign word_out_data  = r_hold;

    // ------------------------------------------------------------------
    // Unpack path
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] r_sh;
    logic [CNT_W-1:0] r_rcnt;
    logic             w_in_rdy;

    assign w_in_rdy = (r_rcnt == '0);

    // Load a word zero-extended to whole beats, then shift one beat out per
    // pop. After the last pop the register is fully shifted out, so
    // pin_rdata returns to zero.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_sh   <= '0;
            r_rcnt <= '0;
        end else if (word_in_valid && w_in_rdy) begin
            r_sh   <= EXT_W'(word_in_data);
            r_rcnt <= NBEAT;
        end else if (pin_deq && !w_in_rdy) begin
            r_sh   <= r_sh >> PIN_W;
            r_rcnt <= r_rcnt - ONE;
        end
    end

    assign word_in_ready = w_in_rdy;
    assign pin_rempty_n  = !w_in_rdy;
    assign pin_rdata     = r_sh[PIN_W-1:0];

    // ------------------------------------------------------------------
    // Status path: one synchroniser, output register and sticky flag per bit
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_STATUS; g++) begin : g_stat
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_stat;
        logic                   r_stky;
        logic                   w_rise;

        assign w_rise = r_sync[SYNC_STAGES-1] && !r_stat;

        // The sticky flag rises on the same edge as status_o. When a rise
        // and a clear arrive together, the rise wins.
        always_ff @(posedge io_clk or negedge io_rst_n) begin
            if (!io_rst_n) begin
                r_sync <= '0;
                r_stat <= 1'b0;
                r_stky <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], status_async_i[g]};
                r_stat <= r_sync[SYNC_STAGES-1];
                if (w_rise)
                    r_stky <= 1'b1;
                else if (status_clr[g])
                    r_stky <= 1'b0;
            end
        end

        assign status_o[g]        = r_stat;
        assign status_sticky_o[g] = r_stky;
    end

endmodule

// File: tb/tb_gpio_stream_bridge.sv
// Bench for gpio_stream_bridge. A queue-based behavioural model runs next to
// the default DUT and is compared on every falling edge. Directed literal
// checks cover the main cases, and a second instance (WORD_W=64) covers a
// word width that is not a whole number of beats.
`timescale 1ns/1ps
module tb_gpio_stream_bridge;
    localparam int PIN_W = 11, WORD_W = 55, NS = 3, SYNC = 2, BEATS = 5;
    localparam int W2 = 64, BEATS2 = 6;

    logic io_clk = 1'b0;
    logic io_rst_n = 1'b0;
    always #5 io_clk = ~io_clk;

    logic              pin_wenq, pin_wfull_n, ovf_o, word_out_valid, word_out_ready;
    logic [PIN_W-1:0]  pin_wdata, pin_rdata;
    logic [WORD_W-1:0] word_out_data, word_in_data;
    logic              word_in_valid, word_in_ready, pin_deq, pin_rempty_n;
    logic [NS-1:0]     status_async_i, status_o, status_sticky_o, status_clr;

    logic              v_wenq, v_wfull_n, v_ovf, v_ovalid, v_oready, v_ivalid, v_iready, v_deq, v_rempty_n;
    logic [PIN_W-1:0]  v_wdata, v_rdata;
    logic [W2-1:0]     v_odata, v_idata;
    logic [NS-1:0]     v_sa, v_so, v_ss, v_sclr;

    gpio_stream_bridge #(.PIN_W(PIN_W), .WORD_W(WORD_W), .NUM_STATUS(NS), .SYNC_STAGES(SYNC)) u_dut (
        .io_clk(io_clk), .io_rst_n(io_rst_n),
        .pin_wenq(pin_wenq), .pin_wdata(pin_wdata), .pin_wfull_n(pin_wfull_n), .ovf_o(ovf_o),
        .word_out_valid(word_out_valid), .word_out_data(word_out_data), .word_out_ready(word_out_ready),
        .word_in_valid(word_in_valid), .word_in_data(word_in_data), .word_in_ready(word_in_ready),
        .pin_deq(pin_deq), .pin_rdata(pin_rdata), .pin_rempty_n(pin_rempty_n),
        .status_async_i(status_async_i), .status_o(status_o),
        .status_sticky_o(status_sticky_o), .status_clr(status_clr)
    );

    gpio_stream_bridge #(.PIN_W(PIN_W), .WORD_W(W2), .NUM_STATUS(NS), .SYNC_STAGES(SYNC)) u_dut64 (
        .io_clk(io_clk), .io_rst_n(io_rst_n),
        .pin_wenq(v_wenq), .pin_wdata(v_wdata), .pin_wfull_n(v_wfull_n), .ovf_o(v_ovf),
        .word_out_valid(v_ovalid), .word_out_data(v_odata), .word_out_ready(v_oready),
        .word_in_valid(v_ivalid), .word_in_data(v_idata), .word_in_ready(v_iready),
        .pin_deq(v_deq), .pin_rdata(v_rdata), .pin_rempty_n(v_rempty_n),
        .status_async_i(v_sa), .status_o(v_so), .status_sticky_o(v_ss), .status_clr(v_sclr)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PIN_W-1:0]  m_beats[$];   // beats collected toward the next word
    logic [WORD_W-1:0] m_hold;
    bit                m_hvld, m_ovf;
    logic [PIN_W-1:0]  m_rq[$];      // beats still to be presented on the pins
    logic [NS-1:0]     m_dly[SYNC];  // status samples in flight
    logic [NS-1:0]     m_st, m_stky;
    bit                chk_en = 1'b0;

    task automatic model_reset();
        m_beats.delete(); m_rq.delete();
        m_hold = '0; m_hvld = 0; m_ovf = 0;
        for (int i = 0; i < SYNC; i++) m_dly[i] = '0;
        m_st = '0; m_stky = '0;
    endtask

    // Advance the model across one rising edge, using the inputs the DUT sampled.
    task automatic model_step();
        bit full;
        logic [127:0] acc;
        logic [NS-1:0] nst;
        if (!io_rst_n) begin model_reset(); return; end
        full = m_hvld && (m_beats.size() == BEATS - 1);
        if (m_hvld && word_out_ready) m_hvld = 0;
        if (pin_wenq) begin
            if (full) m_ovf = 1;
            else begin
                m_beats.push_back(pin_wdata);
                if (m_beats.size() == BEATS) begin
                    acc = '0;
                    for (int k = 0; k < BEATS; k++) acc = acc | (128'(m_beats[k]) << (k * PIN_W));
                    m_hold = acc[WORD_W-1:0];
                    m_hvld = 1;
                    m_beats.delete();
                end
            end
        end
        if (m_rq.size() == 0) begin
            if (word_in_valid)
                for (int k = 0; k < BEATS; k++) m_rq.push_back(PIN_W'(word_in_data >> (k * PIN_W)));
        end else if (pin_deq) begin
            void'(m_rq.pop_front());
        end
        nst = m_dly[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = status_async_i;
        m_stky = (m_stky & ~status_clr) | (nst & ~m_st);
        m_st = nst;
    endtask

    // Compare the DUT against the model on every cycle.
    always @(negedge io_clk) begin
        if (chk_en) begin
            chk("wfull_n", 128'(pin_wfull_n), 128'(!(m_hvld && m_beats.size() == BEATS - 1)));
            chk("ovf", 128'(ovf_o), 128'(m_ovf));
            chk("out_valid", 128'(word_out_valid), 128'(m_hvld));
            chk("out_data", 128'(word_out_data), 128'(m_hold));
            chk("in_ready", 128'(word_in_ready), 128'(m_rq.size() == 0));
            chk("rempty_n", 128'(pin_rempty_n), 128'(m_rq.size() != 0));
            chk("rdata", 128'(pin_rdata), (m_rq.size() != 0) ? 128'(m_rq[0]) : 128'(0));
            chk("status", 128'(status_o), 128'(m_st));
            chk("sticky", 128'(status_sticky_o), 128'(m_stky));
        end
    end

    task automatic tick();
        @(posedge io_clk);
        model_step();
        @(negedge io_clk);
    endtask

    task automatic idle();
        pin_wenq = 0; pin_wdata = '0; word_out_ready = 0; word_in_valid = 0;
        word_in_data = '0; pin_deq = 0; status_clr = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wfull_n"}, 128'(pin_wfull_n), 128'(1));
        chk({tag, "_ovf"}, 128'(ovf_o), 128'(0));
        chk({tag, "_valid"}, 128'(word_out_valid), 128'(0));
        chk({tag, "_data"}, 128'(word_out_data), 128'(0));
        chk({tag, "_in_ready"}, 128'(word_in_ready), 128'(1));
        chk({tag, "_rdata"}, 128'(pin_rdata), 128'(0));
        chk({tag, "_rempty_n"}, 128'(pin_rempty_n), 128'(0));
        chk({tag, "_status"}, 128'(status_o), 128'(0));
        chk({tag, "_sticky"}, 128'(status_sticky_o), 128'(0));
    endtask

    logic [PIN_W-1:0] pv[5];
    logic [PIN_W-1:0] got[BEATS2];
    logic [W2-1:0]    c64;
    logic [127:0]     rebuilt;

    initial begin
        idle();
        status_async_i = '0;
        v_wenq = 0; v_wdata = '0; v_oready = 0; v_ivalid = 0; v_idata = '0; v_deq = 0;
        v_sa = '0; v_sclr = '0;
        model_reset();
        repeat (2) @(negedge io_clk);
        chk_reset_vals("rst0");
        io_rst_n = 1'b1;
        chk_en = 1'b1;

        // Directed pack with the consumer always ready.
        pv[0] = 11'h001; pv[1] = 11'h002; pv[2] = 11'h003; pv[3] = 11'h004; pv[4] = 11'h7FF;
        word_out_ready = 1;
        for (int i = 0; i < 5; i++) begin pin_wenq = 1; pin_wdata = pv[i]; tick(); end
        pin_wenq = 0;
        chk("pack_valid", 128'(word_out_valid), 128'(1));
        chk("pack_word", 128'(word_out_data), 128'(55'h7FF00800C01001));
        chk("pack_ovf", 128'(ovf_o), 128'(0));
        tick();
        chk("pack_valid_clr", 128'(word_out_valid), 128'(0));

        // Backpressure: one word held, a second one complete except for its last beat.
        word_out_ready = 0;
        for (int i = 0; i < 9; i++) begin pin_wenq = 1; pin_wdata = PIN_W'($urandom); tick(); end
        chk("bp_full", 128'(pin_wfull_n), 128'(0));
        pin_wdata = PIN_W'($urandom); tick();
        chk("bp_ovf", 128'(ovf_o), 128'(1));
        pin_wenq = 0; word_out_ready = 1; tick();
        chk("bp_valid_clr", 128'(word_out_valid), 128'(0));
        chk("bp_wfull_n", 128'(pin_wfull_n), 128'(1));
        word_out_ready = 0; pin_wenq = 1; pin_wdata = PIN_W'($urandom); tick();
        chk("bp_word2", 128'(word_out_valid), 128'(1));
        pin_wenq = 0; word_out_ready = 1; tick();
        idle();

        // Unpack an all-ones word.
        word_in_valid = 1; word_in_data = 55'h7F_FFFF_FFFF_FFFF; tick();
        word_in_valid = 0;
        chk("up_ready_lo", 128'(word_in_ready), 128'(0));
        for (int i = 0; i < BEATS; i++) begin
            chk("up_beat", 128'(pin_rdata), 128'(11'h7FF));
            chk("up_rempty", 128'(pin_rempty_n), 128'(1));
            pin_deq = 1; tick();
        end
        pin_deq = 0;
        chk("up_empty", 128'(pin_rempty_n), 128'(0));
        chk("up_ready_hi", 128'(word_in_ready), 128'(1));
        pin_deq = 1; tick(); pin_deq = 0;
        chk("up_deq_empty", 128'(pin_rempty_n), 128'(0));
        chk("up_deq_rdata", 128'(pin_rdata), 128'(0));

        // Status latency, sticky clear, and a clear that coincides with a rise.
        status_async_i = 3'b101;
        tick(); chk("st_lat1", 128'(status_o), 128'(0));
        tick(); chk("st_lat2", 128'(status_o), 128'(0));
        tick(); chk("st_lat3", 128'(status_o), 128'(3'b101));
        chk("st_sticky", 128'(status_sticky_o), 128'(3'b101));
        status_async_i = 3'b100;
        repeat (3) tick();
        status_clr = 3'b001; tick(); status_clr = '0;
        chk("st_clr", 128'(status_sticky_o), 128'(3'b100));
        status_async_i = 3'b101;
        tick(); tick();
        status_clr = 3'b001; tick(); status_clr = '0;
        chk("st_set_wins", 128'(status_sticky_o), 128'(3'b101));

        // Reset in the middle of a pack and an unpack.
        word_out_ready = 1;
        for (int i = 0; i < 3; i++) begin pin_wenq = 1; pin_wdata = PIN_W'($urandom); tick(); end
        pin_wenq = 0; word_in_valid = 1; word_in_data = WORD_W'({$urandom, $urandom}); tick();
        word_in_valid = 0; pin_deq = 1; tick(); tick(); pin_deq = 0;
        #2;
        io_rst_n = 1'b0;
        status_async_i = '0;
        model_reset();
        #1;
        chk_reset_vals("rst_mid");
        tick();
        io_rst_n = 1'b1;
        idle();
        for (int i = 0; i < 5; i++) begin pin_wenq = 1; pin_wdata = 11'h001; tick(); end
        pin_wenq = 0;
        chk("rst_fresh_word", 128'(word_out_data), 128'(55'h100200400801));
        word_out_ready = 1; tick();

        // Randomised traffic on every path.
        for (int c = 0; c < 3000; c++) begin
            pin_wenq       = ($urandom_range(0, 2) != 0);
            pin_wdata      = PIN_W'($urandom);
            word_out_ready = (c % 200 < 120) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            word_in_valid  = ($urandom_range(0, 1) != 0);
            word_in_data   = WORD_W'({$urandom, $urandom});
            pin_deq        = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) status_async_i = NS'($urandom);
            status_clr     = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            tick();
        end
        idle();
        tick();

        // WORD_W=64 instance: the final beat carries only 9 data bits.
        c64 = 64'hDEADBEEF_CAFEF00D;
        v_oready = 0;
        for (int k = 0; k < BEATS2; k++) begin
            v_wenq = 1;
            v_wdata = PIN_W'(c64 >> (k * PIN_W));
            if (k == BEATS2 - 1) v_wdata = v_wdata | 11'h600;
            tick();
        end
        v_wenq = 0;
        chk("v64_valid", 128'(v_ovalid), 128'(1));
        chk("v64_word", 128'(v_odata), 128'(64'hDEADBEEF_CAFEF00D));
        v_oready = 1; tick(); v_oready = 0;
        v_ivalid = 1; v_idata = v_odata; tick(); v_ivalid = 0;
        for (int k = 0; k < BEATS2; k++) begin
            got[k] = v_rdata;
            chk("v64_rempty", 128'(v_rempty_n), 128'(1));
            v_deq = 1; tick();
        end
        v_deq = 0;
        chk("v64_beat0", 128'(got[0]), 128'(11'h00D));
        chk("v64_last", 128'(got[BEATS2-1]), 128'(11'h1BD));
        rebuilt = '0;
        for (int k = 0; k < BEATS2; k++) rebuilt = rebuilt | (128'(got[k]) << (k * PIN_W));
        chk("v64_roundtrip", rebuilt, 128'(64'hDEADBEEF_CAFEF00D));
        chk("v64_done", 128'(v_iready), 128'(1));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
